seg7_readback: RTL and testbench
================================

// Module: seg7_readback
// PURPOSE
//   Receiver side of the seven-segment display path. Samples a time-multiplexed
//   active-low segment bus and its one-hot digit strobe, and waits for each
//   digit to settle. Decodes each settled pattern back to a hex nibble and
//   assembles a full display frame. Used for display loop-back checking and for
//   reading panel state from an external display driver.
// PARAMETERS
//   DIGITS      8   number of multiplexed digits (>=1)
//   STABLE_CYC  4   consecutive identical samples required before capture (>=2)
// PORTS
//   clk        in   1           single clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   seg_in     in   7           segment bus, active-low, bit0=a .. bit6=g
//   dig_sel    in   DIGITS      digit strobe, active-high; valid only when one-hot
//   out_val    out  4*DIGITS    last complete frame; digit i in [4i+3:4i]
//   out_err    out  DIGITS      per-digit flag: pattern was not a legal glyph
//   out_valid  out  1           1-cycle pulse: out_val/out_err just updated
//   busy       out  1           1 while a partial frame is held (any digit seen)
// BEHAVIOUR
//   Glyph table (seg_in hex -> nibble):
//     0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//     8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//     Any other pattern is illegal.
//   Reset (async assert, sync release):
//     - out_val=0, out_err=0, out_valid=0, busy=0.
//     - Shadow buffer=0, seen mask=0, stability counter=0, sample regs=0.
//   Sampling:
//     - Register {dig_sel, seg_in} every edge.
//     - If the current input equals the registered value and dig_sel is
//       one-hot, cnt increments, saturating at STABLE_CYC.
//     - Otherwise cnt=1 when dig_sel is one-hot, else cnt=0.
//   Capture:
//     - Fires on the edge where cnt goes STABLE_CYC-1 -> STABLE_CYC.
//     - Exactly one capture per dwell. A new capture needs an input change
//       and a fresh run of STABLE_CYC samples.
//     - A legal glyph writes its nibble to shadow slot i and clears err bit i.
//     - An illegal glyph writes 0 to slot i and sets err bit i.
//     - seen[i] is set.
//   dig_sel zero or multi-hot: no capture, cnt=0, state otherwise unchanged.
//   Re-capture of a digit already seen this frame: overwrites that slot,
//     latest wins; the frame does not advance.
//   Frame completion:
//     - On the edge after the capture that makes seen all-ones:
//       out_val/out_err load from the shadow, out_valid=1 for one cycle, and
//       seen clears.
//     - Capture to out_valid latency: 1 cycle.
//     - Minimum in-to-out latency: STABLE_CYC+1 cycles from the last digit's
//       first sample.
//   Capture coincident with a completion load: the capture goes into the new
//     frame's shadow, and its seen bit is set after the clear.
//   out_val/out_err hold between frames and never show partial frames.
//   busy = |seen.
//   Reset mid-frame: the partial frame is discarded and out_val returns to 0.
// TESTING
//   1. Reset, then scan digits 0..7 with glyphs 0..7, each held 4 cycles
//      -> single out_valid pulse; out_val=32'h76543210; out_err=0.
//   2. Digit 3 holds seg_in=7'h7F (blank), the others hold legal glyphs for F
//      -> out_err=8'h08; out_val nibble3=0; all other nibbles=F.
//   3. Every digit holds its glyph for only 3 cycles -> no capture, no
//      out_valid, busy=0.
//      Repeat with 4 cycles -> captures occur.
//   4. Mid-dwell, glitch dig_sel to 8'h03 for 1 cycle -> cnt restarts and
//      capture is delayed by the glitch length plus STABLE_CYC cycles.
//   5. Hold digit 0 for 12 cycles with glyph A -> exactly one capture.
//      Then rescan digit 0 with glyph b before completion -> out_val nibble0=b.
//   6. Assert rst after 5 digits are captured -> all outputs 0 immediately.
//      A full rescan is then required before out_valid.

Source files
------------

// File: rtl/seg7_readback.sv
// Seven-segment bus receiver: waits for each multiplexed digit to settle,
// decodes the active-low glyph back to a hex nibble and publishes complete
// frames atomically with a one-cycle out_valid strobe.
module seg7_readback #(
  parameter int DIGITS     = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   out_val,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0]     CNT_ARM = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);

  // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = 5'h00;
      7'h79: r = 5'h01;
      7'h24: r = 5'h02;
      7'h30: r = 5'h03;
      7'h19: r = 5'h04;
      7'h12: r = 5'h05;
      7'h02: r = 5'h06;
      7'h78: r = 5'h07;
      7'h00: r = 5'h08;
      7'h10: r = 5'h09;
      7'h08: r = 5'h0A;
      7'h03: r = 5'h0B;
      7'h46: r = 5'h0C;
      7'h21: r = 5'h0D;
      7'h06: r = 5'h0E;
      7'h0E: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]          seg_q, seg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   sh_err_q, sh_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] out_val_q, out_val_d;
  logic [DIGITS-1:0]   out_err_q, out_err_d;
  logic                out_valid_q, out_valid_d;

  logic                onehot;
  logic                same;
  logic                capture;
  logic                complete;
  logic [4:0]          dec;

  // Settle counting, glyph capture into the shadow frame and frame publication.
  always_comb begin
    sel_d       = dig_sel;
    seg_d       = seg_in;
    cnt_d       = '0;
    shadow_d    = shadow_q;
    sh_err_d    = sh_err_q;
    out_val_d   = out_val_q;
    out_err_d   = out_err_q;
    out_valid_d = 1'b0;
    onehot      = (dig_sel != '0) && ((dig_sel & (dig_sel - SEL_ONE)) == '0);
    same        = (dig_sel == sel_q) && (seg_in == seg_q);
    dec         = decode_glyph(seg_in);
    // Capture only on the edge that first reaches the full run, so a long
    // dwell yields a single capture.
    capture     = onehot && same && (cnt_q == CNT_ARM);
    complete    = &seen_q;

    if (onehot && same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end else if (onehot) begin
      cnt_d = CNT_ONE;
    end

    // Completion publishes the old shadow; a coincident capture lands in
    // the next frame because seen is cleared before its bit is set.
    seen_d = complete ? '0 : seen_q;
    if (complete) begin
      out_val_d   = shadow_q;
      out_err_d   = sh_err_q;
      out_valid_d = 1'b1;
    end

    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_sel[i]) begin
          shadow_d[4*i +: 4] = dec[4] ? 4'h0 : dec[3:0];
          sh_err_d[i]        = dec[4];
          seen_d[i]          = 1'b1;
        end
      end
    end
  end

  // State registers; reset discards any partial frame and clears outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= '0;
      seg_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      sh_err_q    <= '0;
      seen_q      <= '0;
      out_val_q   <= '0;
      out_err_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      sh_err_q    <= sh_err_d;
      seen_q      <= seen_d;
      out_val_q   <= out_val_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_val   = out_val_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign busy      = |seen_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Scoreboard bench for seg7_readback: scenarios push expected frames, a
// monitor pops and compares them on every out_valid pulse.
module tb_seg7_readback;

  localparam int DIGITS = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] out_val;
  logic [DIGITS-1:0]   out_err;
  logic                out_valid;
  logic                busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4*DIGITS-1:0] val;
    logic [DIGITS-1:0]   err;
  } frame_t;

  frame_t exp_q[$];
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_readback #(.DIGITS(DIGITS), .STABLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .out_val(out_val), .out_err(out_err), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every out_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got val=%h err=%h required no pulse", out_val, out_err);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        if (out_val !== e.val) begin
          errors++;
          $display("FAIL frame_val got %h required %h", out_val, e.val);
        end
        checks++;
        if (out_err !== e.err) begin
          errors++;
          $display("FAIL frame_err got %h required %h", out_err, e.err);
        end
      end
    end
  end

  task automatic hold(input int d, input logic [6:0] s, input int n);
    dig_sel = DIGITS'(1) << d;
    seg_in  = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    dig_sel = '0;
    seg_in  = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] e);
    frame_t f;
    f.val = v;
    f.err = e;
    exp_q.push_back(f);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d frames pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dig_sel = '0; seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    checks++; if (out_val !== '0)   begin errors++; $display("FAIL reset_val got %h required 0", out_val); end
    checks++; if (out_err !== '0)   begin errors++; $display("FAIL reset_err got %h required 0", out_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scan();
    push(32'h76543210, 8'h00);
    for (int d = 0; d < DIGITS; d++) hold(d, glyph[d], 4);
    idle(3);
    drain();
  endtask

  task automatic test_illegal();
    push(32'hFFFF0FFF, 8'h08);
    for (int d = 0; d < DIGITS; d++) hold(d, (d == 3) ? 7'h7F : glyph[15], 4);
    idle(3);
    drain();
  endtask

  task automatic test_short_dwell();
    for (int d = 0; d < DIGITS; d++) hold(d, glyph[d], 3);
    idle(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b required 0", busy); end
    push(32'h01234567, 8'h00);
    for (int d = 0; d < DIGITS; d++) hold(d, glyph[7-d], 4);
    idle(3);
    drain();
  endtask

  task automatic test_glitch();
    int n = 0;
    hold(0, glyph[9], 2);
    dig_sel = 8'h03;
    @(negedge clk);
    dig_sel = 8'h01;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL glitch_latency got %0d required 4", n); end
    push(32'h11111119, 8'h00);
    for (int d = 1; d < DIGITS; d++) hold(d, glyph[1], 4);
    idle(3);
    drain();
  endtask

  task automatic test_recapture();
    push(32'h2222222B, 8'h00);
    hold(0, glyph[10], 12);
    for (int d = 1; d < 4; d++) hold(d, glyph[2], 4);
    hold(0, glyph[11], 4);
    for (int d = 4; d < DIGITS; d++) hold(d, glyph[2], 4);
    idle(3);
    drain();
  endtask

  task automatic test_mid_reset();
    for (int d = 0; d < 5; d++) hold(d, glyph[12], 4);
    idle(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b required 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (out_val !== '0)   begin errors++; $display("FAIL midrst_val got %h required 0", out_val); end
    checks++; if (out_err !== '0)   begin errors++; $display("FAIL midrst_err got %h required 0", out_err); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %b required 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 5; d < DIGITS; d++) hold(d, glyph[13], 4);
    idle(3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy got %b required 1", busy); end
    push(32'hDDDEEEEE, 8'h00);
    for (int d = 0; d < 5; d++) hold(d, glyph[14], 4);
    idle(3);
    drain();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_illegal();
    test_short_dwell();
    test_glitch();
    test_recapture();
    test_mid_reset();
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
